// File: rtl/mem_access_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_access_pkg
//  Purpose  : Shared types and lane-mapping constants for the mem_access_ctrl
//             memory sequencer and its byte-lane merge unit.
//  Contents : mem_state_t  - sequencer state encoding
//             lane_idx_t   - byte-lane index (address bits [1:0])
//             lane_lsb()   - bit offset of a lane inside a 32-bit word
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR      = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } mem_state_t;

    typedef logic [1:0] lane_idx_t;

    // Big-endian lanes: lane 0 holds bits 31:24, lane 3 holds bits 7:0.
    function automatic int lane_lsb(input int lane);
        return (NUM_LANES - 1 - lane) * LANE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_byte_lane_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : byte_lane_merge
//  Purpose  : Combinational byte-lane helper. Replaces one lane of a 4-byte
//             word with a new byte (SB merge) and extracts one lane as a
//             sign-extended 32-bit value (LB result).
//  Ports    : src     in  [7:0] x4  source bytes, lane 0 = bits 31:24
//             lane    in  [1:0]     selected lane (address bits [1:0])
//             wbyte   in  [7:0]     byte inserted into the selected lane
//             merged  out [7:0] x4  src with the selected lane replaced
//             extract out [31:0]    selected lane, sign-extended from bit 7
//  Revision : 1.0 - initial release
// ============================================================================
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [7:0]  src [0:3],
    input  logic [1:0]  lane,
    input  logic [7:0]  wbyte,
    output logic [7:0]  merged [0:3],
    output logic [31:0] extract
);

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            merged[i] = (lane == lane_idx_t'(i)) ? wbyte : src[i];
        end
        extract = {{24{src[lane][7]}}, src[lane]};
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Multi-cycle memory sequencer between the core's load/store
//             decode and a byte-lane data memory. Latches one LW/SW/LB/SB
//             request, waits the fixed memory latency, performs
//             read-modify-write for SB and returns a one-cycle response.
//  Params   : MEM_LAT - memory latency in cycles (>= 1)
//  Macro    : MEM_ACCESS_CTRL_ALIGN_CHK_EN - when defined, misaligned word
//             requests complete immediately with rsp_err=1 and no access.
//  Ports    : clk, rst_b (sync, active-high reset)
//             halted, req_valid, req_write, req_byte, req_addr, req_wdata
//             stall, rsp_valid, rsp_rdata, rsp_err
//             mem_addr, mem_data_out (read lanes), mem_data_in (write lanes),
//             mem_write_en
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_out [0:3],
    output logic [7:0]  mem_data_in  [0:3],
    output logic        mem_write_en
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic              byte_q;
    logic              err_q;
    logic [7:0]        rd_buf [0:3];

    logic [7:0]        merge_src [0:3];
    logic [7:0]        merged    [0:3];
    logic [31:0]       lane_ext;
    logic              issue;
    logic              misaligned;
    logic              cnt_last;

    assign issue    = (state == ST_IDLE) & req_valid & ~halted;
    assign cnt_last = (cnt == CNT_W'(1));

`ifdef MEM_ACCESS_CTRL_ALIGN_CHK_EN
    assign misaligned = ~req_byte & (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign stall = issue
                 | (state == ST_RD_WAIT)
                 | (state == ST_WR)
                 | (state == ST_WR_WAIT);

    assign rsp_err      = err_q;
    assign mem_write_en = (state == ST_WR);

    // One merge unit serves both paths: during RD_WAIT it extracts the LB
    // byte from live memory data, during WR it merges the SB byte into the
    // buffered read word.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            merge_src[i] = (state == ST_WR) ? rd_buf[i] : mem_data_out[i];
        end
    end

    byte_lane_merge u_merge (
        .src     (merge_src),
        .lane    (mem_addr[1:0]),
        .wbyte   (wdata_q[7:0]),
        .merged  (merged),
        .extract (lane_ext)
    );

    // Write lanes are decoded from state so they are zero outside WR.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            mem_data_in[i] = 8'h00;
            if (state == ST_WR) begin
                mem_data_in[i] = byte_q ? merged[i] : wdata_q[lane_lsb(i) +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            byte_q    <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                rd_buf[i] <= 8'h00;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        mem_addr <= req_addr;
                        wdata_q  <= req_wdata;
                        write_q  <= req_write;
                        byte_q   <= req_byte;
                        err_q    <= misaligned;
                        if (misaligned) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_write & ~req_byte) begin
                            state <= ST_WR;
                        end else begin
                            // Loads and SB both start with a read.
                            state <= ST_RD_WAIT;
                            cnt   <= CNT_W'(MEM_LAT);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            rd_buf[i] <= mem_data_out[i];
                        end
                        if (write_q) begin
                            state <= ST_WR;
                        end else begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= byte_q ? lane_ext
                                                : {mem_data_out[0], mem_data_out[1],
                                                   mem_data_out[2], mem_data_out[3]};
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR: begin
                    state <= ST_WR_WAIT;
                    cnt   <= CNT_W'(MEM_LAT);
                end
                ST_WR_WAIT: begin
                    if (cnt_last) begin
                        cnt       <= '0;
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // The core advances its PC on this edge, so any request
                    // still visible here belongs to the finished instruction.
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Directed self-checking bench for mem_access_ctrl (MEM_LAT=4)
//             with a 256-byte big-endian memory model.
//  Macro    : MEM_ACCESS_CTRL_ALIGN_CHK_EN selects the expected behaviour of
//             the misaligned-word step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        halted;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_out [0:3];
    logic [7:0]  mem_data_in  [0:3];
    logic        mem_write_en;

    int checks = 0;
    int errors = 0;

    // Results of the last do_req call.
    int          n_stall;
    int          rsp_cyc;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_lanes;
    logic [31:0] rsp_data;
    logic        rsp_e;
    int          we_total = 0;
    int          we_before;
    int          seen;

    logic [7:0]  mem [0:255];

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .halted       (halted),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en)
    );

    // Memory model: word-addressed lanes, write on the strobe edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = mem[{mem_addr[7:2], 2'(i)}];
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                mem[{mem_addr[7:2], 2'(i)}] <= mem_data_in[i];
            end
            we_total <= we_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, hold it until the response, and record
    // per-cycle behaviour. Cycle 0 is the issue cycle.
    task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, input logic halt_mid);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        n_stall = 0; rsp_cyc = -1; we_cnt = 0; we_cyc = -1;
        we_lanes = '0; rsp_data = '0; rsp_e = 1'b0;
        for (int c = 0; c < 40 && rsp_cyc < 0; c++) begin
            #1;
            if (stall) n_stall++;
            if (mem_write_en) begin
                we_cnt++;
                we_cyc   = c;
                we_lanes = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
            end
            if (rsp_valid) begin
                rsp_cyc  = c;
                rsp_data = rsp_rdata;
                rsp_e    = rsp_err;
            end
            if (halt_mid && c == 1) halted = 1'b1;
            @(negedge clk);
        end
        // req_valid was still high at the DONE edge; it must not re-issue.
        req_valid = 1'b0;
        halted    = 1'b0;
        #1;
        chk("post_done_idle", {30'b0, stall, rsp_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b1; halted = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rst_stall",    32'(stall), 32'h0);
        chk("rst_rsp",      {30'b0, rsp_valid, rsp_err}, 32'h0);
        chk("rst_we",       32'(mem_write_en), 32'h0);
        chk("rst_addr",     mem_addr, 32'h0);
        chk("rst_rdata",    rsp_rdata, 32'h0);
        chk("rst_lanes",    {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]}, 32'h0);

        // SW preload 0x10
        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("sw10_lanes", we_lanes, 32'hDEADBEEF);
        chk("sw10_rsp",   32'(rsp_cyc), 32'd6);

        // LW 0x10
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("lw10_stall", 32'(n_stall), 32'd5);
        chk("lw10_rsp",   32'(rsp_cyc), 32'd5);
        chk("lw10_data",  rsp_data, 32'hDEADBEEF);
        chk("lw10_we",    32'(we_cnt), 32'd0);
        chk("lw10_err",   32'(rsp_e), 32'h0);

        // SW 0x20
        do_req(1'b1, 1'b0, 32'h20, 32'h11223344, 1'b0);
        chk("sw20_wecyc", 32'(we_cyc), 32'd1);
        chk("sw20_wecnt", 32'(we_cnt), 32'd1);
        chk("sw20_lanes", we_lanes, 32'h11223344);
        chk("sw20_rsp",   32'(rsp_cyc), 32'd6);
        chk("sw20_stall", 32'(n_stall), 32'd6);
        chk("sw20_rdata", rsp_data, 32'h0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lw20_data",  rsp_data, 32'h11223344);

        // SB 0x22 read-modify-write
        do_req(1'b1, 1'b1, 32'h22, 32'h000000AB, 1'b0);
        chk("sb22_wecyc", 32'(we_cyc), 32'd5);
        chk("sb22_wecnt", 32'(we_cnt), 32'd1);
        chk("sb22_lanes", we_lanes, 32'h1122AB44);
        chk("sb22_rsp",   32'(rsp_cyc), 32'd10);
        chk("sb22_stall", 32'(n_stall), 32'd10);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("lw20_after_sb", rsp_data, 32'h1122AB44);

        // LB sign/zero extension on each lane
        do_req(1'b1, 1'b0, 32'h50, 32'hA5220180, 1'b0);
        do_req(1'b0, 1'b1, 32'h53, 32'h0, 1'b0);
        chk("lb53", rsp_data, 32'hFFFFFF80);
        chk("lb53_rsp", 32'(rsp_cyc), 32'd5);
        do_req(1'b0, 1'b1, 32'h51, 32'h0, 1'b0);
        chk("lb51", rsp_data, 32'h00000022);
        do_req(1'b0, 1'b1, 32'h50, 32'h0, 1'b0);
        chk("lb50", rsp_data, 32'hFFFFFFA5);
        do_req(1'b0, 1'b1, 32'h52, 32'h0, 1'b0);
        chk("lb52", rsp_data, 32'h00000001);

        // halted rising mid-operation: access still completes
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b1);
        chk("halt_mid_rsp",  32'(rsp_cyc), 32'd5);
        chk("halt_mid_data", rsp_data, 32'h1122AB44);

        // Reset during WR_WAIT of SW 0x30
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rstww_stall", 32'(stall), 32'h0);
        chk("rstww_rsp",   32'(rsp_valid), 32'h0);
        chk("rstww_addr",  mem_addr, 32'h0);
        seen = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (rsp_valid || stall) seen++;
        end
        chk("rstww_quiet", 32'(seen), 32'd0);
        do_req(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
        chk("rstww_written", rsp_data, 32'hCAFEF00D);

        // Reset during RD_WAIT of SB 0x41: no write strobe
        do_req(1'b1, 1'b0, 32'h40, 32'h55667788, 1'b0);
        we_before = we_total;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
        req_addr = 32'h41; req_wdata = 32'h00000099;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstrd_no_we", 32'(we_total - we_before), 32'd0);
        do_req(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("rstrd_mem", rsp_data, 32'h55667788);

        // halted in IDLE: request ignored
        @(negedge clk);
        halted = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 32'h10;
        seen = 0;
        repeat (4) begin
            #1;
            if (stall || rsp_valid) seen++;
            @(negedge clk);
        end
        chk("halt_idle_quiet", 32'(seen), 32'd0);
        chk("halt_idle_addr",  mem_addr, 32'h40);
        req_valid = 1'b0; halted = 1'b0;

        // Misaligned word access
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
`ifdef MEM_ACCESS_CTRL_ALIGN_CHK_EN
        chk("mis_rsp",   32'(rsp_cyc), 32'd1);
        chk("mis_err",   32'(rsp_e), 32'h1);
        chk("mis_data",  rsp_data, 32'h0);
        chk("mis_stall", 32'(n_stall), 32'd1);
        chk("mis_we",    32'(we_cnt), 32'd0);
`else
        chk("mis_rsp",   32'(rsp_cyc), 32'd5);
        chk("mis_err",   32'(rsp_e), 32'h0);
        chk("mis_data",  rsp_data, 32'hDEADBEEF);
        chk("mis_addr",  mem_addr, 32'h13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
